// File: rtl/rgb_led_seq_pkg.sv
// Shared types and default parameter values for the RGB LED driver sequencer.
package rgb_led_seq_pkg;

   localparam int DEF_PWM_BITS   = 8;
   localparam int DEF_PRESCALE   = 4;
   localparam int DEF_WARMUP_CYC = 64;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_WARMUP = 2'd1,
      ST_ON     = 2'd2,
      ST_STOP   = 2'd3
   } state_e;

endpackage

// File: rtl/rgb_pwm_timebase.sv
// PWM timebase: prescaler produces a tick every PRESCALE clocks, and the period
// counter steps on each tick through 0..2^PWM_BITS-2. Both counters hold at 0 while run is low.
module rgb_pwm_timebase #(
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                run,
   output logic [PWM_BITS-1:0] cnt,
   output logic                tick,
   output logic                wrap
);

   localparam int                PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(PRESCALE - 1);
   localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

   logic [PSC_W-1:0]    psc_q, psc_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;

   assign tick = run && (psc_q == PSC_LAST);
   assign wrap = tick && (cnt_q == CNT_LAST);
   assign cnt  = cnt_q;

   always_comb begin
      psc_d = psc_q;
      cnt_d = cnt_q;
      if (!run) begin
         psc_d = '0;
         cnt_d = '0;
      end else if (tick) begin
         psc_d = '0;
         cnt_d = wrap ? '0 : cnt_q + PWM_BITS'(1);
      end else begin
         psc_d = psc_q + PSC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         psc_q <= '0;
         cnt_q <= '0;
      end else begin
         psc_q <= psc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rgb_led_seq.sv
// Power-up sequencer and three-channel PWM generator for the constant-current
// RGB LED driver: reference enable, warm-up, driver enable, glitch-free duty updates.
module rgb_led_seq
   import rgb_led_seq_pkg::*;
#(
   parameter int PWM_BITS   = DEF_PWM_BITS,
   parameter int PRESCALE   = DEF_PRESCALE,
   parameter int WARMUP_CYC = DEF_WARMUP_CYC
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                enable,
   input  logic                duty_valid,
   output logic                duty_ready,
   input  logic [PWM_BITS-1:0] duty_r,
   input  logic [PWM_BITS-1:0] duty_g,
   input  logic [PWM_BITS-1:0] duty_b,
   output logic                cur_en,
   output logic                rgbleden,
   output logic                rgb0_pwm,
   output logic                rgb1_pwm,
   output logic                rgb2_pwm,
   output logic                active,
   output state_e              state_dbg
);

   localparam int               WARM_W    = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);

   state_e              state_q;
   logic [WARM_W-1:0]   warm_q;
   logic                cur_en_q, rgbleden_q, active_q;
   logic [2:0]          pwm_q, pwm_cmp;

   logic [PWM_BITS-1:0] cnt;
   logic                tick, wrap;

   logic                        ready_q, ready_d;
   logic [2:0][PWM_BITS-1:0]    pend_q, pend_d;
   logic [2:0][PWM_BITS-1:0]    act_q, act_d;

   rgb_pwm_timebase #(
      .PWM_BITS (PWM_BITS),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk    (clk),
      .resetn (resetn),
      .run    (state_q == ST_ON),
      .cnt    (cnt),
      .tick   (tick),
      .wrap   (wrap)
   );

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         pwm_cmp[i] = (cnt < act_q[i]);
      end
   end

   // Duty handshake: a triple transfers on a clock edge where duty_valid and
   // duty_ready are both high. duty_ready stays low while that triple waits in
   // pending; the offerer must hold any further triple until duty_ready returns.
   // Pending moves to active at once outside ON, or at a period wrap in ON.
   always_comb begin
      ready_d = ready_q;
      pend_d  = pend_q;
      act_d   = act_q;
      if (duty_valid && ready_q) begin
         pend_d  = {duty_b, duty_g, duty_r};
         ready_d = 1'b0;
      end else if (!ready_q && ((state_q != ST_ON) || (tick && wrap))) begin
         act_d   = pend_q;
         ready_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q <= 1'b1;
         pend_q  <= '0;
         act_q   <= '0;
      end else begin
         ready_q <= ready_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_OFF;
         warm_q     <= '0;
         cur_en_q   <= 1'b0;
         rgbleden_q <= 1'b0;
         active_q   <= 1'b0;
         pwm_q      <= '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (enable) begin
                  state_q  <= ST_WARMUP;
                  cur_en_q <= 1'b1;
                  warm_q   <= '0;
               end
            end
            ST_WARMUP: begin
               if (!enable) begin
                  state_q  <= ST_OFF;
                  cur_en_q <= 1'b0;
               end else if (warm_q == WARM_LAST) begin
                  state_q    <= ST_ON;
                  rgbleden_q <= 1'b1;
                  active_q   <= 1'b1;
               end else begin
                  warm_q <= warm_q + WARM_W'(1);
               end
            end
            ST_ON: begin
               if (!enable) begin
                  state_q    <= ST_STOP;
                  rgbleden_q <= 1'b0;
                  active_q   <= 1'b0;
                  pwm_q      <= '0;
               end else begin
                  pwm_q <= pwm_cmp;
               end
            end
            ST_STOP: begin
               // One cycle of reference current after the driver turns off; enable is ignored here.
               state_q  <= ST_OFF;
               cur_en_q <= 1'b0;
            end
            default: state_q <= ST_OFF;
         endcase
      end
   end

   assign duty_ready = ready_q;
   assign cur_en     = cur_en_q;
   assign rgbleden   = rgbleden_q;
   assign active     = active_q;
   assign rgb0_pwm   = pwm_q[0];
   assign rgb1_pwm   = pwm_q[1];
   assign rgb2_pwm   = pwm_q[2];
   assign state_dbg  = state_q;

endmodule
